// File: rtl/piso_pkg.sv
// piso_pkg: shared types and sizing helper for the LSB-first PISO transmitter.
// Contents: state_e (FSM encoding), cnt_w() (bit-counter width for a data width).
// Optional feature macro PISO_PARITY_EN only affects users of PAR, not this file.
package piso_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      PAR   = 2'd2
   } state_e;

   // Counter must be at least one bit wide, even for a single-bit frame.
   function automatic int cnt_w(input int dw);
      return (dw > 1) ? $clog2(dw) : 1;
   endfunction

endpackage

// File: rtl/piso_bit_cnt.sv
// piso_bit_cnt: clearable, enabled up-counter that flags the last bit of a frame.
// Ports: clk, rst (async active-low), clr (sync clear, wins over en), en (count),
//        last (count == DW-1).
module piso_bit_cnt
   import piso_pkg::*;
#(
   parameter int DW = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic last
);

   localparam int CNT_W = cnt_w(DW);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign last = (cnt == CNT_W'(DW - 1));

endmodule

// File: rtl/piso_right_tx.sv
// piso_right_tx: parallel-in serial-out transmitter, LSB first, valid/ready load.
// Ports: clk, rst (async active-low), enb (global advance), load_vld/load_rdy/
//        load_data (word in), out_bit/out_vld (serial out), done (end-of-frame pulse).
// Macro PISO_PARITY_EN appends an even-parity bit after the data bits.
module piso_right_tx
   import piso_pkg::*;
#(
   parameter int DW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          enb,
   input  logic          load_vld,
   input  logic [DW-1:0] load_data,
   output logic          load_rdy,
   output logic          out_bit,
   output logic          out_vld,
   output logic          done
);

   state_e        state;
   logic [DW-1:0] sreg;
   logic [DW-1:0] shifted;
   logic          accept;
   logic          cnt_en;
   logic          last;
`ifdef PISO_PARITY_EN
   logic          par;
`endif

   assign shifted = sreg >> 1;
   assign accept  = (state == IDLE) && load_vld && enb;
   assign cnt_en  = (state == SHIFT) && enb;

   piso_bit_cnt #(.DW(DW)) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (accept),
      .en   (cnt_en),
      .last (last)
   );

   // Outputs are registered alongside the state: out_bit is loaded with the
   // bit that will be on the wire in the next state, so it never glitches.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         sreg     <= '0;
         load_rdy <= 1'b1;
         out_vld  <= 1'b0;
         out_bit  <= 1'b0;
         done     <= 1'b0;
`ifdef PISO_PARITY_EN
         par      <= 1'b0;
`endif
      end else begin
         // done is a single-cycle pulse, independent of enb
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  sreg     <= load_data;
`ifdef PISO_PARITY_EN
                  par      <= ^load_data;
`endif
                  state    <= SHIFT;
                  load_rdy <= 1'b0;
                  out_vld  <= 1'b1;
                  out_bit  <= load_data[0];
               end
            end
            SHIFT: begin
               if (enb) begin
                  sreg <= shifted;
                  if (last) begin
`ifdef PISO_PARITY_EN
                     state    <= PAR;
                     out_bit  <= par;
`else
                     state    <= IDLE;
                     done     <= 1'b1;
                     load_rdy <= 1'b1;
                     out_vld  <= 1'b0;
                     out_bit  <= 1'b0;
`endif
                  end else begin
                     out_bit <= shifted[0];
                  end
               end
            end
`ifdef PISO_PARITY_EN
            PAR: begin
               if (enb) begin
                  state    <= IDLE;
                  done     <= 1'b1;
                  load_rdy <= 1'b1;
                  out_vld  <= 1'b0;
                  out_bit  <= 1'b0;
               end
            end
`endif
            default: begin
               state    <= IDLE;
               load_rdy <= 1'b1;
               out_vld  <= 1'b0;
               out_bit  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_piso_right_tx.sv
// tb_piso_right_tx: self-checking bench for piso_right_tx (DW=4).
// Expected serial streams come from a table of constants and feed a scoreboard
// queue; outputs are checked at every falling edge. Honors PISO_PARITY_EN.
module tb_piso_right_tx;

   localparam int DW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          enb;
   logic          load_vld;
   logic [DW-1:0] load_data;
   logic          load_rdy;
   logic          out_bit;
   logic          out_vld;
   logic          done;

   piso_right_tx #(.DW(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .enb       (enb),
      .load_vld  (load_vld),
      .load_data (load_data),
      .load_rdy  (load_rdy),
      .out_bit   (out_bit),
      .out_vld   (out_vld),
      .done      (done)
   );

   always #5 clk = ~clk;

   // ser lists the bits in transmit order: ser[3] goes out first.
   typedef struct {
      logic [3:0] data;
      logic [3:0] ser;
      logic       par;
   } vec_t;

   vec_t vecs [6];

   logic q [$];
   logic exp_done = 1'b0;
   int   compared = 0;
   int   mismatched = 0;

   task automatic chk(input string name, input logic act, input logic exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Check outputs for the current cycle, advance the model across the
   // coming rising edge, drive the inputs for it, then move to the next negedge.
   task automatic tick(input logic en, input logic lv, input logic [3:0] d,
                       input logic [3:0] ser, input logic p);
      logic busy;
      logic nd;
      busy = (q.size() != 0);
      nd   = 1'b0;
      chk("out_vld", out_vld, busy);
      chk("out_bit", out_bit, busy ? q[0] : 1'b0);
      chk("load_rdy", load_rdy, !busy);
      chk("done", done, exp_done);
      if (rst) begin
         if (busy) begin
            if (en) begin
               if (q.size() == 1) nd = 1'b1;
               void'(q.pop_front());
            end
         end else if (lv && en) begin
            for (int i = 3; i >= 0; i--) q.push_back(ser[i]);
`ifdef PISO_PARITY_EN
            q.push_back(p);
`endif
         end
      end
      exp_done  = nd;
      enb       = en;
      load_vld  = lv;
      load_data = d;
      @(negedge clk);
   endtask

   task automatic idle_tick();
      tick(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
   endtask

   // Run the current frame out, then check the done cycle.
   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 30) begin
         idle_tick();
         n++;
      end
      if (q.size() != 0) begin
         compared++;
         mismatched++;
         $display("FAIL drain_timeout: %0d bits still pending, expected 0", q.size());
         q.delete();
      end
      idle_tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{data: 4'b1011, ser: 4'b1101, par: 1'b1};
      vecs[1] = '{data: 4'b0001, ser: 4'b1000, par: 1'b1};
      vecs[2] = '{data: 4'b1111, ser: 4'b1111, par: 1'b0};
      vecs[3] = '{data: 4'b0110, ser: 4'b0110, par: 1'b0};
      vecs[4] = '{data: 4'b1000, ser: 4'b0001, par: 1'b1};
      vecs[5] = '{data: 4'b0100, ser: 4'b0010, par: 1'b1};

      rst       = 1'b0;
      enb       = 1'b1;
      load_vld  = 1'b1;
      load_data = 4'b1011;
      @(negedge clk);

      // Held in reset with a pending load: nothing accepted.
      tick(1'b1, 1'b1, 4'b1011, 4'b1101, 1'b1);
      tick(1'b1, 1'b1, 4'b1011, 4'b1101, 1'b1);
      rst = 1'b1;

      // Back-to-back table frames at minimum spacing.
      for (int v = 0; v < 6; v++) begin
         tick(1'b1, 1'b1, vecs[v].data, vecs[v].ser, vecs[v].par);
         while (q.size() != 0) idle_tick();
      end
      idle_tick();
      idle_tick();

      // Stall two cycles while bit 1 is on the wire.
      tick(1'b1, 1'b1, 4'b1011, 4'b1101, 1'b1);
      idle_tick();
      tick(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
      tick(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
      drain();

      // Load attempt while busy is ignored, then taken in the idle cycle.
      tick(1'b1, 1'b1, 4'b1011, 4'b1101, 1'b1);
      for (int n = 0; n < 10 && q.size() != 0; n++)
         tick(1'b1, 1'b1, 4'hF, 4'b1111, 1'b0);
      tick(1'b1, 1'b1, 4'hF, 4'b1111, 1'b0);
      drain();

      // Reset asserted mid-frame aborts without done.
      tick(1'b1, 1'b1, 4'b1011, 4'b1101, 1'b1);
      idle_tick();
      rst = 1'b0;
      #1;
      chk("abort_out_vld", out_vld, 1'b0);
      chk("abort_out_bit", out_bit, 1'b0);
      chk("abort_load_rdy", load_rdy, 1'b1);
      chk("abort_done", done, 1'b0);
      q.delete();
      exp_done = 1'b0;
      @(negedge clk);
      tick(1'b1, 1'b1, 4'b0001, 4'b1000, 1'b1);
      rst = 1'b1;
      tick(1'b1, 1'b1, 4'b0001, 4'b1000, 1'b1);
      drain();

      // Parity-oriented word (odd number of ones).
      tick(1'b1, 1'b1, 4'b0111, 4'b1110, 1'b1);
      drain();
      idle_tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/piso_right_tx.md
# piso_right_tx

Parallel-in, serial-out transmitter, LSB first: the sending end of the team's shift-right SIPO receiver, whose serial input feeds its MSB. A word captured through a valid/ready load handshake is emitted one bit per enabled cycle. A bit counter detects the end of the frame, and a one-cycle `done` pulse marks completion. It sits between a parallel producer and a single-wire serial link in the same clock domain.

## Interface
- `DW`, default 4: data width in bits (≥1).
- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `enb` in 1: shift/accept enable; while low, all state holds except `done` clearing.
- `load_vld` in 1: producer has a word on `load_data`.
- `load_data` in DW: parallel word to transmit.
- `load_rdy` out 1: transmitter idle, can accept a word.
- `out_bit` out 1: serial data, LSB first.
- `out_vld` out 1: `out_bit` carries a frame bit this cycle.
- `done` out 1: one-cycle pulse after the last frame bit.

## Operation
- Reset values: state IDLE, shift register 0, counter 0, `load_rdy`=1, `out_vld`=0, `out_bit`=0, `done`=0.
- FSM states: IDLE, SHIFT, PAR. PAR exists only with the parity macro.
- IDLE: `load_rdy`=1. On `load_vld & enb` at an edge:
  - capture `load_data` into the shift register;
  - clear the counter;
  - go to SHIFT.
  - `load_vld` with `enb`=0 is not accepted.
- SHIFT: `out_vld`=1 and `out_bit`=`sreg[0]`. On each edge with `enb`=1:
  - `sreg <= {1'b0, sreg[DW-1:1]}` (shift right, zero fill at MSB);
  - increment the counter.
  - When the counter is DW-1 and `enb`=1, leave SHIFT: go to PAR if the parity macro is defined, else go to IDLE and set `done`.
- `load_vld` is ignored outside IDLE (`load_rdy`=0); `load_data` is sampled only at acceptance.
- `out_bit` is forced to 0 whenever `out_vld`=0.
- Counter width is `$clog2(DW)`, minimum 1. With DW=1, the frame is one SHIFT cycle.
- `done` is registered: high for exactly one cycle, the first IDLE cycle after the frame. It clears on the next edge regardless of `enb`.
- Reset asserted mid-frame aborts immediately to reset values; no `done` pulse is produced.

## Timing
- Acceptance edge N: bit 0 appears in cycle N+1, bit k in the (k+1)th enabled SHIFT cycle.
- Without parity: a frame occupies DW enabled cycles. `done` and `load_rdy` assert together in the cycle after the last bit.
- Minimum load-to-load spacing is DW+1 cycles (one idle cycle between frames, with no overlap of `load_rdy` and `out_vld`).
- With `enb` low during SHIFT, `out_bit`/`out_vld` hold their current values; each stall extends the frame by one cycle.

## Configuration
- `PISO_PARITY_EN` defined:
  - the XOR of the captured word is registered at acceptance;
  - after the last data bit the FSM enters PAR for one enabled cycle with `out_vld`=1 and `out_bit`=parity (even parity: data plus parity has an even count of ones);
  - on leaving PAR the FSM goes to IDLE with `done`;
  - frame length is DW+1.
- Not defined: no PAR state, no parity register; frame length is DW.

## Structure
- Package `piso_pkg`:
  - `state_e` enum (IDLE, SHIFT, PAR);
  - localparam helper for counter width `CNT_W = (DW>1) ? $clog2(DW) : 1`.
- Sub-module `piso_bit_cnt`: clearable, enabled up-counter with `last` flag at DW-1. It is instantiated once; the FSM and shift register remain in the top.

## Test plan
- Reset: hold `rst`=0 with `load_vld`=1 → `load_rdy`=1, `out_vld`=0, `out_bit`=0, `done`=0. Release: first accept occurs only on a later edge.
- DW=4, `enb`=1, load 4'b1011 → `out_bit` 1,1,0,1 on four consecutive cycles with `out_vld`=1. Next cycle: `done`=1 for one cycle, `load_rdy`=1.
- Same word, `enb` low for 2 cycles after bit 1 → `out_bit` stays 1 for 3 cycles. The sequence completes 1,1,0,1 over 6 cycles, with a single `done`.
- While busy, drive `load_vld`=1 with `load_data`=4'hF → ignored. Serial output still 1,1,0,1, then 4'hF is accepted in the IDLE cycle.
- Drop `rst` to 0 after bit 1 → immediate `out_vld`=0, `load_rdy`=1, no `done`. A new load 4'b0001 sends 1,0,0,0.
- `PISO_PARITY_EN`, load 4'b0111 → 1,1,1,0 then parity bit 1 (5 `out_vld` cycles), then `done`.
